// File: rtl/eqn_serial_cmp_amisha.sv
// Bit-serial MSB-first unsigned magnitude comparator with early exit on the first
// differing bit, plus a saturating count of equal results.
module eqn_serial_cmp_amisha #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic             start_amisha,
    input  logic [WIDTH-1:0] a_amisha,
    input  logic [WIDTH-1:0] b_amisha,
    input  logic             clr_cnt_amisha,
    output logic             busy_amisha,
    output logic             done_amisha,
    output logic             eq_amisha,
    output logic             gt_amisha,
    output logic             lt_amisha,
    output logic [CNT_W-1:0] match_cnt_amisha
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             eq_reg, eq_next;
    logic             gt_reg, gt_next;
    logic             lt_reg, lt_next;
    logic             resolved_reg, resolved_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic bit_a;
    logic bit_b;
    assign bit_a = a_reg[idx_reg];
    assign bit_b = b_reg[idx_reg];

    always_ff @(posedge clk_amisha) begin
        if (!rst_n_amisha) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            idx_reg      <= '0;
            eq_reg       <= 1'b0;
            gt_reg       <= 1'b0;
            lt_reg       <= 1'b0;
            resolved_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            idx_reg      <= idx_next;
            eq_reg       <= eq_next;
            gt_reg       <= gt_next;
            lt_reg       <= lt_next;
            resolved_reg <= resolved_next;
            cnt_reg      <= cnt_next;
        end
    end

    // The decision on a bit is registered first (resolved_reg); the move to DONE
    // happens on the following edge, giving done at start edge + K + 1.
    always_comb begin
        state_next    = state_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        idx_next      = idx_reg;
        eq_next       = eq_reg;
        gt_next       = gt_reg;
        lt_next       = lt_reg;
        resolved_next = resolved_reg;
        case (state_reg)
            IDLE: begin
                if (start_amisha) begin
                    a_next        = a_amisha;
                    b_next        = b_amisha;
                    idx_next      = IDX_TOP;
                    eq_next       = 1'b0;
                    gt_next       = 1'b0;
                    lt_next       = 1'b0;
                    resolved_next = 1'b0;
                    state_next    = CMP;
                end
            end
            CMP: begin
                if (resolved_reg) begin
                    state_next = DONE;
                end else if (bit_a != bit_b) begin
                    gt_next       = bit_a;
                    lt_next       = bit_b;
                    resolved_next = 1'b1;
                end else if (idx_reg == '0) begin
                    eq_next       = 1'b1;
                    resolved_next = 1'b1;
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end
            DONE: begin
                resolved_next = 1'b0;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (clr_cnt_amisha) begin
            cnt_next = '0;
        end else if (state_reg == CMP && resolved_reg && eq_reg && cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    assign busy_amisha      = (state_reg == CMP) || (state_reg == DONE);
    assign done_amisha      = (state_reg == DONE);
    assign eq_amisha        = eq_reg;
    assign gt_amisha        = gt_reg;
    assign lt_amisha        = lt_reg;
    assign match_cnt_amisha = cnt_reg;

endmodule
